idecode: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline.
- Consumes the IF/ID latch outputs of the fetch stage (IF_ID_instr, IF_ID_npc).
- Decodes control, reads a 32x32 register file and sign-extends the immediate.
- Registers everything into the ID/EX latch for the execute stage.
- Accepts the write-back port (MEM_WB_*) into the register file.

---
 rtl/idecode_pkg.sv | 31 +++
 rtl/idecode_register_file.sv | 53 +++++
 rtl/idecode.sv | 111 +++++++++++
 tb/tb_idecode.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/idecode_pkg.sv
// Shared constants and types for the MIPS instruction-decode stage.
package idecode_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int REG_N_DFLT  = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Bit positions inside the wb = {RegWrite, MemtoReg} and m = {Branch, MemRead, MemWrite} vectors
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/idecode_register_file.sv
// 2-read/1-write register file with register 0 hardwired to zero.
// Optional write-through bypass on the read ports when IDECODE_BYPASS_EN is defined.
module register_file
  import idecode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_N  = REG_N_DFLT,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_reg [REG_N];
  logic              wr_en;
  logic [AW-1:0]     raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign wr_en    = we && (waddr != '0);
  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  assign rdata1   = rdata[0];
  assign rdata2   = rdata[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs_reg[i] <= '0;
    end else if (wr_en) begin
      regs_reg[waddr] <= wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef IDECODE_BYPASS_EN
      // The write lands in the first half-cycle, so a same-cycle read sees it
      assign rdata[gi] = (raddr[gi] == '0) ? '0 :
                         (wr_en && (waddr == raddr[gi])) ? wdata : regs_reg[raddr[gi]];
`else
      assign rdata[gi] = (raddr[gi] == '0) ? '0 : regs_reg[raddr[gi]];
`endif
    end
  endgenerate

endmodule

// File: rtl/idecode.sv
// MIPS ID stage: control decode, register read, sign extension, ID/EX latch.
// Define IDECODE_BYPASS_EN to make same-cycle write-back visible to the read.
module idecode
  import idecode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_N  = REG_N_DFLT,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       IF_ID_instr,
  input  logic [DATA_W-1:0] IF_ID_npc,
  input  logic              MEM_WB_RegWrite,
  input  logic [AW-1:0]     MEM_WB_writereg,
  input  logic [DATA_W-1:0] WB_writedata,
  output logic [1:0]        ID_EX_wb,
  output logic [2:0]        ID_EX_m,
  output logic              ID_EX_regdst,
  output logic              ID_EX_alusrc,
  output logic [1:0]        ID_EX_aluop,
  output logic [DATA_W-1:0] ID_EX_npc,
  output logic [DATA_W-1:0] ID_EX_readdat1,
  output logic [DATA_W-1:0] ID_EX_readdat2,
  output logic [DATA_W-1:0] ID_EX_sign_ext,
  output logic [4:0]        ID_EX_instr_2016,
  output logic [4:0]        ID_EX_instr_1511
);

  logic [5:0]        opcode;
  ctrl_t             ctrl_next;
  logic [DATA_W-1:0] readdat1_next;
  logic [DATA_W-1:0] readdat2_next;
  logic [DATA_W-1:0] sign_ext_next;

  assign opcode        = IF_ID_instr[31:26];
  assign sign_ext_next = {{(DATA_W-16){IF_ID_instr[15]}}, IF_ID_instr[15:0]};

  register_file #(
    .DATA_W(DATA_W),
    .REG_N (REG_N)
  ) u_register_file (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr1(IF_ID_instr[25:21]),
    .raddr2(IF_ID_instr[20:16]),
    .rdata1(readdat1_next),
    .rdata2(readdat2_next),
    .we    (MEM_WB_RegWrite),
    .waddr (MEM_WB_writereg),
    .wdata (WB_writedata)
  );

  // Unknown opcodes decode to all-zero control, i.e. a bubble
  always_comb begin
    ctrl_next = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_next.wb[WB_REGWRITE] = 1'b1;
        ctrl_next.regdst          = 1'b1;
        ctrl_next.aluop           = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_next.wb[WB_REGWRITE] = 1'b1;
        ctrl_next.wb[WB_MEMTOREG] = 1'b1;
        ctrl_next.m[M_MEMREAD]    = 1'b1;
        ctrl_next.alusrc          = 1'b1;
        ctrl_next.aluop           = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_next.m[M_MEMWRITE]   = 1'b1;
        ctrl_next.alusrc          = 1'b1;
        ctrl_next.aluop           = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_next.m[M_BRANCH]     = 1'b1;
        ctrl_next.aluop           = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_wb         <= '0;
      ID_EX_m          <= '0;
      ID_EX_regdst     <= 1'b0;
      ID_EX_alusrc     <= 1'b0;
      ID_EX_aluop      <= '0;
      ID_EX_npc        <= '0;
      ID_EX_readdat1   <= '0;
      ID_EX_readdat2   <= '0;
      ID_EX_sign_ext   <= '0;
      ID_EX_instr_2016 <= '0;
      ID_EX_instr_1511 <= '0;
    end else begin
      ID_EX_wb         <= ctrl_next.wb;
      ID_EX_m          <= ctrl_next.m;
      ID_EX_regdst     <= ctrl_next.regdst;
      ID_EX_alusrc     <= ctrl_next.alusrc;
      ID_EX_aluop      <= ctrl_next.aluop;
      ID_EX_npc        <= IF_ID_npc;
      ID_EX_readdat1   <= readdat1_next;
      ID_EX_readdat2   <= readdat2_next;
      ID_EX_sign_ext   <= sign_ext_next;
      ID_EX_instr_2016 <= IF_ID_instr[20:16];
      ID_EX_instr_1511 <= IF_ID_instr[15:11];
    end
  end

endmodule

// File: tb/tb_idecode.sv
// Scoreboard bench for idecode: stimulus pushes expected ID/EX contents, a monitor pops and compares.
module tb_idecode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IF_ID_instr = '0;
  logic [31:0] IF_ID_npc = '0;
  logic        MEM_WB_RegWrite = 1'b0;
  logic [4:0]  MEM_WB_writereg = '0;
  logic [31:0] WB_writedata = '0;
  logic [1:0]  ID_EX_wb;
  logic [2:0]  ID_EX_m;
  logic        ID_EX_regdst;
  logic        ID_EX_alusrc;
  logic [1:0]  ID_EX_aluop;
  logic [31:0] ID_EX_npc;
  logic [31:0] ID_EX_readdat1;
  logic [31:0] ID_EX_readdat2;
  logic [31:0] ID_EX_sign_ext;
  logic [4:0]  ID_EX_instr_2016;
  logic [4:0]  ID_EX_instr_1511;

  idecode dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .IF_ID_instr     (IF_ID_instr),
    .IF_ID_npc       (IF_ID_npc),
    .MEM_WB_RegWrite (MEM_WB_RegWrite),
    .MEM_WB_writereg (MEM_WB_writereg),
    .WB_writedata    (WB_writedata),
    .ID_EX_wb        (ID_EX_wb),
    .ID_EX_m         (ID_EX_m),
    .ID_EX_regdst    (ID_EX_regdst),
    .ID_EX_alusrc    (ID_EX_alusrc),
    .ID_EX_aluop     (ID_EX_aluop),
    .ID_EX_npc       (ID_EX_npc),
    .ID_EX_readdat1  (ID_EX_readdat1),
    .ID_EX_readdat2  (ID_EX_readdat2),
    .ID_EX_sign_ext  (ID_EX_sign_ext),
    .ID_EX_instr_2016(ID_EX_instr_2016),
    .ID_EX_instr_1511(ID_EX_instr_1511)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rf [32];
  int          n_checks = 0;
  int          n_errors = 0;

  // Control table: {wb, m, regdst, alusrc, aluop}
  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'd0:    return {2'b10, 3'b000, 1'b1, 1'b0, 2'b10};
      6'd35:   return {2'b11, 3'b010, 1'b0, 1'b1, 2'b00};
      6'd43:   return {2'b00, 3'b001, 1'b0, 1'b1, 2'b00};
      6'd4:    return {2'b00, 3'b100, 1'b0, 1'b0, 2'b01};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
`ifdef IDECODE_BYPASS_EN
    if (we && wa != 5'd0 && wa == idx) return wd;
`endif
    return model_rf[idx];
  endfunction

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s %s: got %h required %h", tag, nm, act, req);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] npc,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic rst);
    exp_t              e;
    logic [8:0]        c;
    logic signed [15:0] imm;
    @(negedge clk);
    IF_ID_instr     = instr;
    IF_ID_npc       = npc;
    MEM_WB_RegWrite = we;
    MEM_WB_writereg = wa;
    WB_writedata    = wd;
    rst_n           = !rst;
    e.tag = tag;
    if (rst) begin
      e.wb = '0; e.m = '0; e.regdst = 1'b0; e.alusrc = 1'b0; e.aluop = '0;
      e.npc = '0; e.rd1 = '0; e.rd2 = '0; e.sext = '0; e.rt = '0; e.rd = '0;
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    end else begin
      c        = ref_ctrl(instr[31:26]);
      e.wb     = c[8:7];
      e.m      = c[6:4];
      e.regdst = c[3];
      e.alusrc = c[2];
      e.aluop  = c[1:0];
      e.npc    = npc;
      e.rd1    = ref_read(instr[25:21], we, wa, wd);
      e.rd2    = ref_read(instr[20:16], we, wa, wd);
      imm      = instr[15:0];
      e.sext   = 32'(imm);
      e.rt     = instr[20:16];
      e.rd     = instr[15:11];
      if (we && wa != 5'd0) model_rf[wa] = wd;
    end
    exp_q.push_back(e);
    $display("step %s instr=%h npc=%h we=%0d wa=%0d wd=%h rst=%0d", tag, instr, npc, we, wa, wd, rst);
  endtask

  // Monitor: the latch updates every edge, so each edge with a pending expectation is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "wb",        {30'd0, ID_EX_wb},         {30'd0, e.wb});
        chk(e.tag, "m",         {29'd0, ID_EX_m},          {29'd0, e.m});
        chk(e.tag, "regdst",    {31'd0, ID_EX_regdst},     {31'd0, e.regdst});
        chk(e.tag, "alusrc",    {31'd0, ID_EX_alusrc},     {31'd0, e.alusrc});
        chk(e.tag, "aluop",     {30'd0, ID_EX_aluop},      {30'd0, e.aluop});
        chk(e.tag, "npc",       ID_EX_npc,                 e.npc);
        chk(e.tag, "readdat1",  ID_EX_readdat1,            e.rd1);
        chk(e.tag, "readdat2",  ID_EX_readdat2,            e.rd2);
        chk(e.tag, "sign_ext",  ID_EX_sign_ext,            e.sext);
        chk(e.tag, "instr2016", {27'd0, ID_EX_instr_2016}, {27'd0, e.rt});
        chk(e.tag, "instr1511", {27'd0, ID_EX_instr_1511}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    logic [5:0]  ops [5];
    logic [31:0] ri;
    logic [4:0]  wa;
    ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4; ops[4] = 6'd0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

    // Reset held with random inputs, then sweep all registers
    for (int i = 0; i < 4; i++)
      step("reset", $urandom, $urandom, 1'b1, 5'($urandom), $urandom, 1'b1);
    step("rel", 32'h0, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 1; i < 32; i++)
      step("clr", {6'd0, 5'(i), 5'(i), 16'h0}, 32'(i * 4), 1'b0, 5'd0, 32'h0, 1'b0);

    // Write then read
    step("wr5", 32'h0, 32'h100, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    step("add", 32'h00A53020, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);

    // Decode cases
    step("lw",  32'h8C22FFFC, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0);
    step("sw",  32'hAC220008, 32'h14, 1'b0, 5'd0, 32'h0, 1'b0);
    step("beq", 32'h10220003, 32'h18, 1'b0, 5'd0, 32'h0, 1'b0);
    step("ill", {6'd63, 26'h2A5F00F}, 32'h1C, 1'b0, 5'd0, 32'h0, 1'b0);

    // Register 0 ignores writes
    step("wr0", 32'h0, 32'h20, 1'b1, 5'd0, 32'h12345678, 1'b0);
    step("rd0", 32'h00000000, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0);

    // Same-cycle hazard, then reset during a write
    step("wr7", 32'h0, 32'h28, 1'b1, 5'd7, 32'h11111111, 1'b0);
    step("haz", 32'h00E73820, 32'h2C, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0);
    step("haz+1", 32'h00E73820, 32'h30, 1'b0, 5'd0, 32'h0, 1'b0);
    step("rstwr", 32'h00E73820, 32'h34, 1'b1, 5'd7, 32'h5A5A5A5A, 1'b1);
    step("rd7", 32'h00E73820, 32'h38, 1'b0, 5'd0, 32'h0, 1'b0);

    // Randomized traffic with frequent read/write collisions
    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      ri[31:26] = ($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 4)];
      wa = ($urandom_range(0, 2) == 0) ? ri[25:21] : 5'($urandom);
      step("rand", ri, $urandom, 1'($urandom), wa, $urandom, ($urandom_range(0, 60) == 0));
    end
    step("tail", 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("end", "queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
